// File: rtl/uart_tx_fifo_scheduler_if.sv
// Bus bundle between uart_tx_fifo_scheduler and its producers, byte FIFO and UART transmitter.
// flag_err exists only when FIFO_FLAG_CHECK_EN is defined.
interface uart_tx_fifo_scheduler_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              fifo_en;
  logic              fifo_rst;
  logic              fifo_wr;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_din;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic [LVL_W-1:0]  level;
`ifdef FIFO_FLAG_CHECK_EN
  logic              flag_err;
`endif

  // Scheduler side
  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output fifo_en, fifo_rst, fifo_wr, fifo_rd, fifo_din,
    input  fifo_dout, fifo_empty, fifo_full,
    output tx_start, tx_data,
    input  tx_busy,
    output level
`ifdef FIFO_FLAG_CHECK_EN
    , output flag_err
`endif
  );

  // Environment side: producers, FIFO and transmitter
  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  fifo_en, fifo_rst, fifo_wr, fifo_rd, fifo_din,
    output fifo_dout, fifo_empty, fifo_full,
    input  tx_start, tx_data,
    output tx_busy,
    input  level
`ifdef FIFO_FLAG_CHECK_EN
    , input flag_err
`endif
  );
endinterface

// File: rtl/uart_tx_fifo_scheduler.sv
// Round-robin merge of two byte producers into a shared UART FIFO and drain FSM into the transmitter.
// Optional FIFO_FLAG_CHECK_EN adds a sticky flag_err comparing FIFO flags against the local level.
module uart_tx_fifo_scheduler #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned TX_GAP       = 0,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  uart_tx_fifo_scheduler_if.master  bus
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned GAP_W = 8;
  localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, LAUNCH, WAIT_HI, WAIT_LO, GAP
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [LVL_W-1:0]   level_q;
  logic               last_grant;
  logic [DATA_W-1:0]  tx_data_q;
  logic               tx_start_q;
  logic               fifo_rd_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TO_W-1:0]    to_cnt;

  logic               slot_free;
  logic               grant1;
  logic               wr0;
  logic               wr1;
  logic               wr_c;
  logic               gap_done;
  logic               to_done;

  // Write arbitration: never grants in the read cycle or when the local count is full
  always_comb begin
    slot_free = (state != RD_REQ) && (level_q < LVL_W'(DEPTH));
    grant1    = bus.req1_valid && (!bus.req0_valid || !last_grant);
    wr1       = slot_free && grant1;
    wr0       = slot_free && bus.req0_valid && !grant1;
    wr_c      = wr0 || wr1;
  end

  assign bus.req0_ready = wr0;
  assign bus.req1_ready = wr1;
  assign bus.fifo_en    = 1'b1;
  assign bus.fifo_rst   = Rst;
  assign bus.fifo_wr    = wr_c;
  assign bus.fifo_din   = grant1 ? bus.req1_data : bus.req0_data;
  assign bus.fifo_rd    = fifo_rd_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.level      = level_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Drain FSM next state
  always_comb begin
    state_nx = state;
    gap_done = (TX_GAP == 0) || (gap_cnt == GAP_W'(TX_GAP - 1));
    to_done  = (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
    case (state)
      IDLE:    if ((level_q != '0) && !bus.tx_busy) state_nx = RD_REQ;
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT_HI;
      WAIT_HI: begin
        if (bus.tx_busy)  state_nx = WAIT_LO;
        else if (to_done) state_nx = GAP;
      end
      WAIT_LO: if (!bus.tx_busy) state_nx = GAP;
      GAP:     if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Occupancy, grant history, strobes and transmit byte
  always_ff @(posedge Clk) begin
    if (Rst) begin
      level_q    <= '0;
      last_grant <= 1'b1;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      fifo_rd_q  <= 1'b0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
    end else begin
      tx_start_q <= (state_nx == LAUNCH);
      fifo_rd_q  <= (state_nx == RD_REQ);
      if (state == RD_WAIT) tx_data_q <= bus.fifo_dout;
      if (wr_c) begin
        level_q    <= level_q + LVL_W'(1);
        last_grant <= grant1;
      end else if (state == RD_REQ) begin
        level_q <= level_q - LVL_W'(1);
      end
      gap_cnt <= ((state == GAP) && (state_nx == GAP)) ? gap_cnt + GAP_W'(1) : '0;
      to_cnt  <= ((state == WAIT_HI) && (state_nx == WAIT_HI)) ? to_cnt + TO_W'(1) : '0;
    end
  end

`ifdef FIFO_FLAG_CHECK_EN
  logic prev_io;
  logic flag_err_q;

  // Flags are only trusted once a cycle has passed without a FIFO access
  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev_io    <= 1'b0;
      flag_err_q <= 1'b0;
    end else begin
      prev_io <= wr_c || fifo_rd_q;
      if (!prev_io && (((level_q == '0) != bus.fifo_empty) ||
                       ((level_q == LVL_W'(DEPTH)) != bus.fifo_full)))
        flag_err_q <= 1'b1;
    end
  end

  assign bus.flag_err = flag_err_q;
`else
  logic unused_flags;
  assign unused_flags = bus.fifo_empty ^ bus.fifo_full;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_scheduler.sv
// Bench for uart_tx_fifo_scheduler: FIFO and transmitter models, byte scoreboard, arbitration table.
// Define FIFO_FLAG_CHECK_EN on both RTL and bench to exercise flag_err.
module tb_uart_tx_fifo_scheduler;
  localparam int DATA_W       = 8;
  localparam int DEPTH        = 32;
  localparam int TX_GAP       = 3;
  localparam int BUSY_TIMEOUT = 4;
  localparam int BUSY_LEN     = 10;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  uart_tx_fifo_scheduler_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_tx_fifo_scheduler #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TX_GAP(TX_GAP), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Registered-read byte FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [4:0] wp = '0;
  logic [4:0] rp = '0;
  logic [5:0] cnt = '0;
  logic force_ne = 1'b0;
  always @(posedge Clk) begin
    if (bus.fifo_rst) begin
      wp <= '0; rp <= '0; cnt <= '0; bus.fifo_dout <= '0;
    end else begin
      if (bus.fifo_wr) begin mem[wp] <= bus.fifo_din; wp <= wp + 5'd1; end
      if (bus.fifo_rd) begin bus.fifo_dout <= mem[rp]; rp <= rp + 5'd1; end
      cnt <= cnt + 6'(bus.fifo_wr) - 6'(bus.fifo_rd);
    end
  end
  assign bus.fifo_empty = force_ne ? 1'b0 : (cnt == 6'd0);
  assign bus.fifo_full  = (cnt == 6'd32);

  // Transmitter: 0 = busy never rises, 1 = busy held high, 2 = busy BUSY_LEN cycles per byte
  int tx_mode  = 0;
  int busy_cnt = 0;
  always @(posedge Clk) begin
    if (Rst) busy_cnt <= 0;
    else if (bus.tx_start && tx_mode == 2) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (tx_mode == 1) || (busy_cnt != 0);

  // Scoreboard and protocol monitor
  logic [7:0] sb[$];
  logic [7:0] acc_q[$];
  int start_cyc[$];
  int starts = 0, overlap = 0, rd_pulses = 0, rd_b2b = 0, last_acc_cyc = 0;
  logic prev_rd = 1'b0;
  always @(negedge Clk) begin
    if (Rst) begin
      sb.delete();
      prev_rd <= 1'b0;
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(bus.req0_data); acc_q.push_back(bus.req0_data); last_acc_cyc <= cyc;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(bus.req1_data); acc_q.push_back(bus.req1_data); last_acc_cyc <= cyc;
      end
      if (bus.fifo_wr && bus.fifo_rd) overlap <= overlap + 1;
      if (bus.fifo_rd) begin
        rd_pulses <= rd_pulses + 1;
        if (prev_rd) rd_b2b <= rd_b2b + 1;
      end
      prev_rd <= bus.fifo_rd;
      if (bus.tx_start) begin
        starts <= starts + 1;
        start_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL tx_start: launched 0x%0h with no byte queued", bus.tx_data);
        end else begin
          check("tx_data order", 32'(bus.tx_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(negedge Clk);
    check("fifo_rst with Rst", 32'(bus.fifo_rst), 32'd1);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  // Called at posedge+1; holds valid until accepted, returns at posedge+1
  task automatic push(input int p, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    if (p == 0) begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    else        begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge Clk);
      ok = (p == 0) ? bus.req0_ready : bus.req1_ready;
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("push accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int i;
    i = 0;
    while (starts < target && i < budget) begin tick(); i++; end
    check(name, 32'(starts), 32'(target));
  endtask

  typedef struct {
    logic       v0;
    logic       v1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic [5:0] lvl;
  } vec_t;
  vec_t vecs[10];

  int s0, n0, rd0;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 8'hA0, 8'hB0, 1'b1, 1'b0, 6'd1};
    vecs[1] = '{1'b1, 1'b1, 8'hA1, 8'hB1, 1'b0, 1'b1, 6'd2};
    vecs[2] = '{1'b1, 1'b0, 8'hA2, 8'hB2, 1'b1, 1'b0, 6'd3};
    vecs[3] = '{1'b1, 1'b0, 8'hA3, 8'hB3, 1'b1, 1'b0, 6'd4};
    vecs[4] = '{1'b0, 1'b1, 8'hA4, 8'hB4, 1'b0, 1'b1, 6'd5};
    vecs[5] = '{1'b1, 1'b1, 8'hA5, 8'hB5, 1'b1, 1'b0, 6'd6};
    vecs[6] = '{1'b0, 1'b0, 8'hA6, 8'hB6, 1'b0, 1'b0, 6'd6};
    vecs[7] = '{1'b1, 1'b1, 8'hA7, 8'hB7, 1'b0, 1'b1, 6'd7};
    vecs[8] = '{1'b0, 1'b1, 8'hA8, 8'hB8, 1'b0, 1'b1, 6'd8};
    vecs[9] = '{1'b1, 1'b1, 8'hA9, 8'hB9, 1'b1, 1'b0, 6'd9};

    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    tx_mode = 2;

    // Reset state
    tick();
    do_reset();
    @(negedge Clk);
    check("reset level", 32'(bus.level), 32'd0);
    check("reset tx_start", 32'(bus.tx_start), 32'd0);
    check("reset fifo_rd", 32'(bus.fifo_rd), 32'd0);
    check("reset tx_data", 32'(bus.tx_data), 32'd0);
    check("fifo_en", 32'(bus.fifo_en), 32'd1);
    check("fifo_rst low", 32'(bus.fifo_rst), 32'd0);

    // Single byte: four-cycle latency to tx_start
    tick();
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
    @(negedge Clk);
    check("t1 ready0", 32'(bus.req0_ready), 32'd1);
    check("t1 fifo_wr", 32'(bus.fifo_wr), 32'd1);
    check("t1 fifo_din", 32'(bus.fifo_din), 32'hA5);
    tick();
    bus.req0_valid = 1'b0;
    @(negedge Clk);
    check("t1 fifo_wr one cycle", 32'(bus.fifo_wr), 32'd0);
    tick();
    wait_starts(1, 20, "t1 tx_start seen");
    check("t1 latency", 32'(start_cyc[start_cyc.size()-1] - last_acc_cyc), 32'd4);
    check("t1 level drained", 32'(bus.level), 32'd0);
    check("t1 tx_data held", 32'(bus.tx_data), 32'hA5);
    repeat (30) tick();

    // Arbitration table with busy held so nothing drains
    tx_mode = 1;
    do_reset();
    foreach (vecs[i]) begin
      bus.req0_valid = vecs[i].v0; bus.req0_data = vecs[i].d0;
      bus.req1_valid = vecs[i].v1; bus.req1_data = vecs[i].d1;
      @(negedge Clk);
      check($sformatf("vec%0d ready0", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
      check($sformatf("vec%0d ready1", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
      check($sformatf("vec%0d fifo_wr", i), 32'(bus.fifo_wr), 32'(vecs[i].r0 | vecs[i].r1));
      if (vecs[i].r0 | vecs[i].r1)
        check($sformatf("vec%0d fifo_din", i), 32'(bus.fifo_din),
              32'(vecs[i].r0 ? vecs[i].d0 : vecs[i].d1));
      tick();
      check($sformatf("vec%0d level", i), 32'(bus.level), 32'(vecs[i].lvl));
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Both producers saturating until the count reaches DEPTH, then full drain
    tick();
    do_reset();
    acc_q.delete();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
    repeat (40) tick();
    @(negedge Clk);
    check("t2 ready0 at full", 32'(bus.req0_ready), 32'd0);
    check("t2 ready1 at full", 32'(bus.req1_ready), 32'd0);
    check("t2 level full", 32'(bus.level), 32'(DEPTH));
    check("t2 accepted count", 32'(acc_q.size()), 32'(DEPTH));
    begin
      int bad;
      bad = 0;
      foreach (acc_q[i]) if (acc_q[i] != ((i % 2 == 0) ? 8'h11 : 8'h22)) bad++;
      check("t2 alternation errors", 32'(bad), 32'd0);
    end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    s0 = starts;
    tx_mode = 2;
    wait_starts(s0 + DEPTH, 1200, "t2 drained byte count");
    repeat (30) tick();
    check("t2 level empty", 32'(bus.level), 32'd0);
    check("t2 scoreboard empty", 32'(sb.size()), 32'd0);

    // Five bytes, busy pulses of BUSY_LEN, TX_GAP idle cycles
    tx_mode = 1;
    do_reset();
    for (int i = 0; i < 5; i++) push(1, 8'(8'h31 + i));
    @(negedge Clk);
    check("t3 level loaded", 32'(bus.level), 32'd5);
    tick();
    s0 = starts; n0 = start_cyc.size(); rd0 = rd_pulses;
    tx_mode = 2;
    wait_starts(s0 + 5, 200, "t3 five launches");
    for (int k = 1; k < 5; k++)
      if (n0 + k < start_cyc.size())
        check($sformatf("t3 launch spacing %0d", k),
              32'(start_cyc[n0+k] - start_cyc[n0+k-1]), 32'(2 + BUSY_LEN + TX_GAP + 3));
    check("t3 fifo_rd pulses", 32'(rd_pulses - rd0), 32'd5);
    check("t3 fifo_rd single cycle", 32'(rd_b2b), 32'd0);
    check("t3 rd/wr overlap", 32'(overlap), 32'd0);
    repeat (30) tick();

    // Busy never rises: WAIT_HI times out and the next byte still launches
    tx_mode = 0;
    do_reset();
    s0 = starts; n0 = start_cyc.size();
    push(0, 8'h41);
    push(0, 8'h42);
    wait_starts(s0 + 2, 100, "t4 both launched");
    if (n0 + 1 < start_cyc.size())
      check("t4 timeout spacing", 32'(start_cyc[n0+1] - start_cyc[n0]),
            32'(1 + BUSY_TIMEOUT + TX_GAP + 3));
    repeat (30) tick();
    check("t4 no extra launch", 32'(starts), 32'(s0 + 2));

    // Rst during WAIT_LO with bytes still queued
    tx_mode = 1;
    do_reset();
    for (int i = 0; i < 8; i++) push(0, 8'(8'h51 + i));
    s0 = starts;
    tx_mode = 2;
    wait_starts(s0 + 1, 50, "t5 first launch");
    repeat (4) tick();
    @(negedge Clk);
    check("t5 level before Rst", 32'(bus.level), 32'd7);
    tick();
    Rst = 1'b1;
    @(negedge Clk);
    check("t5 fifo_rst", 32'(bus.fifo_rst), 32'd1);
    tick();
    Rst = 1'b0;
    @(negedge Clk);
    check("t5 level cleared", 32'(bus.level), 32'd0);
    check("t5 tx_start low", 32'(bus.tx_start), 32'd0);
    check("t5 fifo_rd low", 32'(bus.fifo_rd), 32'd0);
    check("t5 tx_data cleared", 32'(bus.tx_data), 32'd0);
    s0 = starts;
    repeat (40) tick();
    check("t5 no launch after Rst", 32'(starts), 32'(s0));
    push(1, 8'h5A);
    wait_starts(s0 + 1, 20, "t5 relaunch after new write");
    check("t5 relaunch latency", 32'(start_cyc[start_cyc.size()-1] - last_acc_cyc), 32'd4);
    repeat (30) tick();

`ifdef FIFO_FLAG_CHECK_EN
    // Flag consistency: sticky error on a forced empty mismatch
    @(negedge Clk);
    check("t6 flag_err clean", 32'(bus.flag_err), 32'd0);
    tick();
    force_ne = 1'b1;
    repeat (3) tick();
    check("t6 flag_err set", 32'(bus.flag_err), 32'd1);
    force_ne = 1'b0;
    repeat (3) tick();
    check("t6 flag_err sticky", 32'(bus.flag_err), 32'd1);
    do_reset();
    @(negedge Clk);
    check("t6 flag_err cleared", 32'(bus.flag_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo_scheduler.md
Name: uart_tx_fifo_scheduler

Overview:
Sits between two byte producers and the UART TX path.
- Arbitrates both producers round-robin into one shared 32-entry UART byte FIFO.
- Drains the FIFO into the UART transmitter with a start/busy handshake.
- Guarantees the FIFO never sees RD and WR in the same cycle, and keeps its own authoritative occupancy count.

Parameters:
DATA_W, 8, byte width of producers, FIFO and transmitter
DEPTH, 32, FIFO capacity in entries; the write limit for the local count
TX_GAP, 0, idle cycles inserted after each byte before the next FIFO read (0..255)
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before giving up

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
req0_valid  in  1  producer 0 has a byte
req0_data  in  DATA_W  producer 0 byte
req0_ready  out  1  producer 0 byte accepted this cycle (comb)
req1_valid  in  1  producer 1 has a byte
req1_data  in  DATA_W  producer 1 byte
req1_ready  out  1  producer 1 byte accepted this cycle (comb)
fifo_en  out  1  FIFO enable, constant 1
fifo_rst  out  1  FIFO reset, equals Rst (comb)
fifo_wr  out  1  FIFO write strobe (comb)
fifo_rd  out  1  FIFO read strobe (registered state decode)
fifo_din  out  DATA_W  byte to FIFO (comb mux of granted producer)
fifo_dout  in  DATA_W  FIFO registered read data
fifo_empty  in  1  FIFO EMPTY flag (used only under the optional feature)
fifo_full  in  1  FIFO FULL flag (used only under the optional feature)
tx_start  out  1  one-cycle pulse: send tx_data
tx_data  out  DATA_W  byte for transmitter, held stable from LAUNCH until next LAUNCH
tx_busy  in  1  transmitter busy
level  out  clog2(DEPTH+1)  local occupancy count

Behaviour:
Reset (Clk edge with Rst=1):
- state=IDLE, level=0, tx_data=0, tx_start=0, fifo_rd=0, gap/timeout counters=0.
- Last-grant register=1, so producer 0 wins the first contention.
- fifo_rst follows Rst, so FIFO pointers clear in the same cycle.
- Rst mid-byte aborts the FSM immediately. A byte already launched is not re-sent.

Write side:
- Write slot is free when state!=RD_REQ and level<DEPTH.
- Only valid producers are granted. One valid producer: it is granted. Both valid: grant the one not granted last.
- reqN_ready = free slot AND granted. Transfer happens when valid&&ready.
- On transfer: fifo_wr=1, fifo_din=granted data, last-grant<=N, level+1.
- A producer must hold valid/data until ready.

Drain FSM:
- IDLE: if level!=0 and tx_busy=0 -> RD_REQ.
- RD_REQ: fifo_rd=1 for exactly one cycle; level-1; no write granted this cycle -> RD_WAIT.
- RD_WAIT: FIFO dataOut now valid; tx_data<=fifo_dout -> LAUNCH.
- LAUNCH: tx_start=1 for one cycle -> WAIT_HI.
- WAIT_HI: tx_busy=1 -> WAIT_LO; else after BUSY_TIMEOUT cycles -> GAP.
- WAIT_LO: tx_busy=0 -> GAP.
- GAP: count TX_GAP cycles (0 means pass straight through in one cycle) -> IDLE.

Timing and arithmetic:
- Latency from first write into an empty FIFO to tx_start = 4 cycles: IDLE, RD_REQ, RD_WAIT, LAUNCH.
- level never wraps: writes are blocked at DEPTH, and reads happen only when level!=0.
- Write and read are mutually exclusive per cycle, so level changes by at most ±1 per cycle.

Optional Feature:
Macro FIFO_FLAG_CHECK_EN.
- Defined: adds output flag_err (1 bit, sticky, cleared only by Rst). flag_err is set when, in a cycle with no fifo_wr/fifo_rd in the previous cycle, (level==0)!=fifo_empty or (level==DEPTH)!=fifo_full.
- Undefined: no flag_err port; fifo_empty/fifo_full are unused.

Test Plan:
1. Rst 3 cycles, then req0 writes 0xA5 once -> fifo_wr one cycle; 4 cycles later tx_start=1, tx_data=0xA5; level back to 0.
2. req0 and req1 both valid continuously with 0x11/0x22, tx_busy held 1 -> accepts alternate 0x11,0x22,0x11,...; writes stop at level=32; both ready=0 afterwards.
3. level=5, tx_busy toggles high 10 cycles per byte, TX_GAP=3 -> 5 tx_start pulses, each ≥3 idle cycles after busy falls; fifo_rd and fifo_wr never high together.
4. tx_busy stuck 0 after tx_start -> WAIT_HI exits after 4 cycles; next byte launches; no hang.
5. Rst asserted during WAIT_LO with level=7 -> next cycle level=0, state IDLE, tx_start=0, fifo_rst=1 with Rst; no further tx_start until new writes.
6. FIFO_FLAG_CHECK_EN defined, fifo_empty forced 0 while level=0 -> flag_err=1 and stays 1 until Rst.
